// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
// One transaction per request; ack completes it and qualifies rdata.
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_byteEn;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteEn, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteEn, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one data-memory transaction per instruction,
// load alignment/extension, and a one-cycle writeback packet.
//
//   state  | meaning
//   IDLE   | ready for a new instruction
//   ACCESS | memory request outstanding, waiting for ack or timeout
//   RESP   | writeback packet presented for one cycle
module mem_access_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     load_in,
    input  logic                     loadUnsigned_in,
    input  logic                     store_in,
    input  logic [1:0]               memLength_in,
    input  logic [DATA_WIDTH-1:0]    address_in,
    input  logic [DATA_WIDTH-1:0]    storeData_in,
    input  logic [REGADDR_WIDTH-1:0] writeSelect_in,
    input  logic                     writeEnable_in,
    input  logic                     flush,
    mem_access_stage_if.master       mem,
    output logic                     wb_valid,
    output logic [REGADDR_WIDTH-1:0] wb_writeSelect,
    output logic                     wb_writeEnable,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     wb_misaligned,
    output logic                     wb_busError
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    logic [1:0]               r_state;
    logic                     r_store;
    logic                     r_unsigned;
    logic [1:0]               r_len;
    logic [DATA_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_sdata;
    logic [REGADDR_WIDTH-1:0] r_sel;
    logic                     r_we;
    logic                     r_misal;
    logic                     r_busErr;
    logic                     r_squash;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_access;
    logic                     w_isMem;
    logic                     w_misal;
    logic [3:0]               w_byteEn;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH-1:0]    w_shifted;
    logic [DATA_WIDTH-1:0]    w_loadData;

    assign w_access = (r_state == S_ACCESS);
    assign w_isMem  = load_in | store_in;

    always_comb begin
        w_misal = 1'b0;
        case (memLength_in)
            LEN_BYTE: w_misal = 1'b0;
            LEN_HALF: w_misal = address_in[0];
            LEN_WORD: w_misal = (address_in[1:0] != 2'b00);
            default:  w_misal = 1'b1;
        endcase
    end

    always_comb begin
        w_byteEn = 4'b0000;
        w_wdata  = '0;
        case (r_len)
            LEN_BYTE: begin
                w_byteEn = 4'b0001 << r_addr[1:0];
                w_wdata  = {4{r_sdata[7:0]}};
            end
            LEN_HALF: begin
                w_byteEn = 4'b0011 << r_addr[1:0];
                w_wdata  = {2{r_sdata[15:0]}};
            end
            default: begin
                w_byteEn = 4'b1111;
                w_wdata  = r_sdata;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend.
    assign w_shifted = mem.mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_loadData = w_shifted;
        case (r_len)
            LEN_BYTE: w_loadData = r_unsigned ? {24'd0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            LEN_HALF: w_loadData = r_unsigned ? {16'd0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:  w_loadData = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_len      <= 2'd0;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_misal    <= 1'b0;
            r_busErr   <= 1'b0;
            r_squash   <= 1'b0;
            r_result   <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_store    <= store_in;
                        r_unsigned <= loadUnsigned_in;
                        r_len      <= memLength_in;
                        r_addr     <= address_in;
                        r_sdata    <= storeData_in;
                        r_sel      <= writeSelect_in;
                        r_we       <= writeEnable_in;
                        r_busErr   <= 1'b0;
                        r_squash   <= flush;
                        r_cnt      <= '0;
                        if (!w_isMem) begin
                            r_misal  <= 1'b0;
                            r_result <= address_in;
                            r_state  <= S_RESP;
                        end else if (w_misal) begin
                            r_misal  <= 1'b1;
                            r_result <= '0;
                            r_state  <= S_RESP;
                        end else begin
                            r_misal  <= 1'b0;
                            r_result <= '0;
                            r_state  <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_squash <= r_squash | flush;
                    // An ack on the final timeout cycle still completes normally.
                    if (mem.mem_ack) begin
                        r_result <= r_store ? '0 : w_loadData;
                        r_cnt    <= '0;
                        r_state  <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_busErr <= 1'b1;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_squash <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_out      = (r_state == S_IDLE);

    assign mem.mem_req    = w_access;
    assign mem.mem_we     = w_access & r_store;
    assign mem.mem_addr   = w_access ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem.mem_byteEn = w_access ? w_byteEn : 4'b0000;
    assign mem.mem_wdata  = w_access ? w_wdata : '0;

    // A flush arriving in the response cycle itself also suppresses the packet.
    assign wb_valid       = (r_state == S_RESP) & ~r_squash & ~flush;
    assign wb_writeSelect = wb_valid ? r_sel : '0;
    assign wb_data        = wb_valid ? r_result : '0;
    assign wb_misaligned  = wb_valid & r_misal;
    assign wb_busError    = wb_valid & r_busErr;
    assign wb_writeEnable = wb_valid & r_we & ~r_store & ~r_misal & ~r_busErr
                          & (r_sel != '0);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations;
// MEM_TIMEOUT is set to 4 so the timeout path is short.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        load_in = 1'b0;
    logic        loadUnsigned_in = 1'b0;
    logic        store_in = 1'b0;
    logic [1:0]  memLength_in = 2'd0;
    logic [31:0] address_in = '0;
    logic [31:0] storeData_in = '0;
    logic [4:0]  writeSelect_in = '0;
    logic        writeEnable_in = 1'b0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_writeSelect;
    logic        wb_writeEnable;
    logic [31:0] wb_data;
    logic        wb_misaligned;
    logic        wb_busError;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage_if #(.DATA_WIDTH(32)) mif ();

    mem_access_stage #(
        .DATA_WIDTH(32), .REGADDR_WIDTH(5), .MEM_TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .load_in        (load_in),
        .loadUnsigned_in(loadUnsigned_in),
        .store_in       (store_in),
        .memLength_in   (memLength_in),
        .address_in     (address_in),
        .storeData_in   (storeData_in),
        .writeSelect_in (writeSelect_in),
        .writeEnable_in (writeEnable_in),
        .flush          (flush),
        .mem            (mif.master),
        .wb_valid       (wb_valid),
        .wb_writeSelect (wb_writeSelect),
        .wb_writeEnable (wb_writeEnable),
        .wb_data        (wb_data),
        .wb_misaligned  (wb_misaligned),
        .wb_busError    (wb_busError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic ld, input logic uns, input logic st,
                         input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] sel, input logic we);
        load_in         = ld;
        loadUnsigned_in = uns;
        store_in        = st;
        memLength_in    = len;
        address_in      = addr;
        storeData_in    = sd;
        writeSelect_in  = sel;
        writeEnable_in  = we;
        valid_in        = 1'b1;
        tick();
        valid_in = 1'b0;
        load_in  = 1'b0;
        store_in = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rd);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rd;
        tick();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
    endtask

    initial begin
        int n;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;

        #12;
        chk("rst_ready", ready_out, 1);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_wbv", wb_valid, 0);
        rst_n = 1'b1;
        tick();

        // non-memory pass-through
        issue(0, 0, 0, 2'd2, 32'h1234, 0, 5'd5, 1);
        chk("nm_wbv", wb_valid, 1);
        chk("nm_data", wb_data, 32'h1234);
        chk("nm_we", wb_writeEnable, 1);
        chk("nm_sel", wb_writeSelect, 5);
        chk("nm_req", mif.mem_req, 0);
        tick();
        chk("nm_wbv_off", wb_valid, 0);
        chk("nm_ready", ready_out, 1);

        // signed byte load at 0x103, two wait cycles
        issue(1, 0, 0, 2'd0, 32'h103, 0, 5'd7, 1);
        chk("lb_req", mif.mem_req, 1);
        chk("lb_we", mif.mem_we, 0);
        chk("lb_addr", mif.mem_addr, 32'h100);
        chk("lb_be", mif.mem_byteEn, 4'b1000);
        chk("lb_ready", ready_out, 0);
        tick();
        chk("lb_hold_addr", mif.mem_addr, 32'h100);
        tick();
        chk("lb_hold_req", mif.mem_req, 1);
        ack_now(32'h80FF_FFFF);
        chk("lb_req_drop", mif.mem_req, 0);
        chk("lb_wbv", wb_valid, 1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wen", wb_writeEnable, 1);
        tick();

        // unsigned byte load, ack in first access cycle
        issue(1, 1, 0, 2'd0, 32'h103, 0, 5'd7, 1);
        chk("lbu_wbv_early", wb_valid, 0);
        ack_now(32'h80FF_FFFF);
        chk("lbu_data", wb_data, 32'h0000_0080);
        tick();

        // signed half load at 0x002
        issue(1, 0, 0, 2'd1, 32'h002, 0, 5'd9, 1);
        chk("lh_be", mif.mem_byteEn, 4'b1100);
        ack_now(32'h8001_7777);
        chk("lh_data", wb_data, 32'hFFFF_8001);
        tick();

        // half store at 0x202
        issue(0, 0, 1, 2'd1, 32'h202, 32'hABCD_1234, 5'd3, 1);
        chk("sh_we", mif.mem_we, 1);
        chk("sh_addr", mif.mem_addr, 32'h200);
        chk("sh_be", mif.mem_byteEn, 4'b1100);
        chk("sh_wdata", mif.mem_wdata, 32'h1234_1234);
        ack_now(32'h0);
        chk("sh_wbv", wb_valid, 1);
        chk("sh_wen", wb_writeEnable, 0);
        tick();

        // load+store together acts as a byte store at 0x101
        issue(1, 0, 1, 2'd0, 32'h101, 32'h0000_005A, 5'd3, 1);
        chk("sb_we", mif.mem_we, 1);
        chk("sb_be", mif.mem_byteEn, 4'b0010);
        chk("sb_wdata", mif.mem_wdata, 32'h5A5A_5A5A);
        ack_now(32'h0);
        chk("sb_wen", wb_writeEnable, 0);
        tick();

        // misaligned word load at 0x006
        issue(1, 0, 0, 2'd2, 32'h006, 0, 5'd4, 1);
        chk("mis_req", mif.mem_req, 0);
        chk("mis_wbv", wb_valid, 1);
        chk("mis_flag", wb_misaligned, 1);
        chk("mis_wen", wb_writeEnable, 0);
        tick();
        chk("mis_flag_off", wb_misaligned, 0);

        // illegal length
        issue(1, 0, 0, 2'd3, 32'h000, 0, 5'd4, 1);
        chk("ill_req", mif.mem_req, 0);
        chk("ill_flag", wb_misaligned, 1);
        tick();

        // aligned load to r0 never writes
        issue(1, 0, 0, 2'd2, 32'h040, 0, 5'd0, 1);
        ack_now(32'h1111_2222);
        chk("r0_wbv", wb_valid, 1);
        chk("r0_data", wb_data, 32'h1111_2222);
        chk("r0_wen", wb_writeEnable, 0);
        tick();

        // timeout: request held exactly MEM_TIMEOUT cycles
        issue(1, 0, 0, 2'd2, 32'h010, 0, 5'd6, 1);
        n = 0;
        while (mif.mem_req && n < 20) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 4);
        chk("to_wbv", wb_valid, 1);
        chk("to_buserr", wb_busError, 1);
        chk("to_wen", wb_writeEnable, 0);
        tick();
        chk("to_ready", ready_out, 1);
        chk("to_buserr_off", wb_busError, 0);

        // ack on the final timeout cycle wins
        issue(1, 0, 0, 2'd2, 32'h010, 0, 5'd6, 1);
        tick();
        tick();
        tick();
        chk("tw_req", mif.mem_req, 1);
        ack_now(32'hDEAD_BEEF);
        chk("tw_buserr", wb_busError, 0);
        chk("tw_data", wb_data, 32'hDEAD_BEEF);
        chk("tw_wen", wb_writeEnable, 1);
        tick();

        // asynchronous reset mid-access
        issue(1, 0, 0, 2'd2, 32'h080, 0, 5'd2, 1);
        chk("ar_req_pre", mif.mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_req", mif.mem_req, 0);
        chk("ar_ready", ready_out, 1);
        tick();
        rst_n = 1'b1;
        tick();
        issue(0, 0, 0, 2'd0, 32'h55AA, 0, 5'd8, 1);
        chk("ar_after_data", wb_data, 32'h55AA);
        chk("ar_after_wen", wb_writeEnable, 1);
        tick();

        // flush during access: transaction completes, no writeback
        issue(1, 0, 0, 2'd2, 32'h020, 0, 5'd4, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_req_kept", mif.mem_req, 1);
        ack_now(32'h1234_5678);
        chk("fl_wbv", wb_valid, 0);
        chk("fl_wen", wb_writeEnable, 0);
        chk("fl_data", wb_data, 0);
        tick();
        chk("fl_ready", ready_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
